tc_bitmem_arbiter: RTL
======================

# tc_bitmem_arbiter

Shared single-bit storage bank with a round-robin arbiter, letting several TC-style requesters read and write one bank of bit memory cells. Each cycle it grants at most one requester a single-cell read or write, and it provides a sequenced bulk-clear. It sits between the per-component load/save logic and the bit cells, replacing per-requester private cells when storage must be shared.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `ADDR_W`, 3: cell address width; bank holds `2**ADDR_W` cells
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: asynchronous, active-low reset
- `req` in NREQ: per-requester access request, level; held until acknowledged
- `we` in NREQ: per-requester 1 = write, 0 = read; qualified by `req`
- `addr` in NREQ*ADDR_W: per-requester cell address, requester i at bits [i*ADDR_W +: ADDR_W]
- `wdata` in NREQ: per-requester write bit
- `clr` in 1: bulk-clear start pulse
- `ack` out NREQ: one-hot, one-cycle pulse marking the serviced requester
- `rdata` out 1: read result, valid while the matching `ack` bit is high
- `busy` out 1: high while a bulk clear is in progress
- `cells` out 2**ADDR_W: live view of all stored bits
- `lock` in NREQ: present only with `TC_BITMEM_ARB_LOCK_EN`; see Configuration

## Operation
- Reset (`rst`=0, asynchronous): all cells 0, `ack`=0, `rdata`=0, `busy`=0, round-robin pointer=0, state=IDLE.
- States:
  - IDLE: arbitrate.
  - CLEAR: sweep the bank.
  - LOCKED: macro builds only.
- IDLE:
  - On each rising edge with any `req` high, select the winner: the first requester with `req` set, searching from the pointer upward with wraparound.
  - Perform the winner's access and pulse `ack[winner]`.
  - Set pointer = (winner+1) mod NREQ.
  - With no `req`, nothing changes.
- Write: `cells[addr]` <= `wdata` at the arbitration edge; `rdata` is driven to the written value.
- Read: `rdata` <= `cells[addr]` as stored before that edge.
- `clr`:
  - Sampled high in IDLE, it takes precedence over any `req` that edge.
  - Go to CLEAR and load the sweep counter with 0; `busy`=1 from the next cycle.
- CLEAR:
  - Clear one cell per edge, address = counter; counter increments.
  - After cell `2**ADDR_W-1` is cleared, return to IDLE, `busy`=0, pointer unchanged.
  - `req` is ignored and `ack` stays 0; requesters keep `req` asserted and are served after the sweep.
  - A `clr` during CLEAR is ignored.
- Requester obligation: hold `req`/`we`/`addr`/`wdata` stable until its `ack`. `req` still high on the edge ending the `ack` cycle counts as a new request and competes normally.
- `rst` low mid-sweep or mid-lock: immediate return to the reset state; any partial sweep is abandoned and all cells read 0.

## Timing
- Latency: `req` high before edge N gives `ack` and `rdata` valid during cycle N→N+1. One access per cycle maximum.
- `ack` is registered: no combinational path from `req` to `ack`.
- `cells` reflects a write from the edge it occurs.
- Clear duration: `2**ADDR_W` cycles of `busy`=1; first `ack` possible on the edge after `busy` falls.
- Worst-case wait for a continuously requesting port without lock: NREQ-1 cycles.

## Configuration
- `TC_BITMEM_ARB_LOCK_EN` defined:
  - Adds the `lock` input and the LOCKED state.
  - If the winner has `lock[winner]`=1 at its grant, enter LOCKED: only that requester is arbitrated, and it is served every cycle its `req` is high.
  - Leave LOCKED on the first edge where that requester's `lock`=0 and `req`=0.
  - `clr` is deferred (held pending) until LOCKED exits.
  - Pointer advances past the owner on exit.
- Undefined: no `lock` port, no LOCKED state, pure round-robin.

## Test plan
- Reset with cells written, `rst`=0 mid-cycle → `cells`=0, `ack`=0, `rdata`=0 immediately, no clock needed.
- NREQ=4, `req`=4'b1111 held 8 cycles, pointer 0 → `ack` sequence 0001,0010,0100,1000,0001,…
- Req0 writes 1 to addr 5, then req1 reads addr 5 → req1 `ack` with `rdata`=1, `cells`[5]=1.
- All cells 1, `clr` pulse with `req`=4'b0010 pending → `busy`=1 for 8 cycles, `cells`=0, then `ack`=4'b0010 on the following cycle.
- `clr` during CLEAR at cycle 3 → no restart, `busy` still falls after 8 total cycles.
- Macro on: req2 with `lock`=1, plus req0 active → only req2 acked for 4 cycles; after lock/req drop, `ack`=4'b0001 next.

Source files
------------

// File: rtl/tc_bitmem_arbiter.sv
// tc_bitmem_arbiter: shared bank of single-bit cells behind a round-robin arbiter.
// One read or write is granted per cycle. A bulk clear sweeps one cell per cycle.
// Optional build macro TC_BITMEM_ARB_LOCK_EN adds a lock input and a LOCKED state. In that
// state, one requester keeps the bank to itself.
module tc_bitmem_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ-1:0]          wdata,
  input  logic                     clr,
`ifdef TC_BITMEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          ack,
  output logic                     rdata,
  output logic                     busy,
  output logic [2**ADDR_W-1:0]     cells
);

  localparam int unsigned NCELL = 2**ADDR_W;
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StClear, StLocked} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NCELL-1:0]    cells_q, cells_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                rdata_q, rdata_d;

  logic                rr_any;
  logic [PW-1:0]       rr_win;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       gidx_next;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic                sel_wdata;
  logic                do_access;

`ifdef TC_BITMEM_ARB_LOCK_EN
  logic [PW-1:0]       owner_q, owner_d;
  logic                pend_q, pend_d;
  logic                sel_req;
  logic                sel_lock;
`endif

  // Round-robin search: first requester at or above the pointer, with wraparound
  always_comb begin
    rr_any = 1'b0;
    rr_win = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned cand;
      cand = (32'(ptr_q) + k) % NREQ;
      if (!rr_any && req[cand[PW-1:0]]) begin
        rr_any = 1'b1;
        rr_win = cand[PW-1:0];
      end
    end
  end

`ifdef TC_BITMEM_ARB_LOCK_EN
  assign gidx = (state_q == StLocked) ? owner_q : rr_win;
`else
  assign gidx = rr_win;
`endif
  assign gidx_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  // Route the granted requester's fields to the bank
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = 1'b0;
`ifdef TC_BITMEM_ARB_LOCK_EN
    sel_req   = 1'b0;
    sel_lock  = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == PW'(i)) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_we    = we[i];
        sel_wdata = wdata[i];
`ifdef TC_BITMEM_ARB_LOCK_EN
        sel_req   = req[i];
        sel_lock  = lock[i];
`endif
      end
    end
  end

  // Next-state: arbitration, clear sweep and (optionally) locked ownership
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    cells_d   = cells_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    do_access = 1'b0;
`ifdef TC_BITMEM_ARB_LOCK_EN
    owner_d   = owner_q;
    pend_d    = pend_q;
`endif
    case (state_q)
      StIdle: begin
        // Clear wins over any request on the same edge
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (rr_any) begin
          do_access = 1'b1;
          ptr_d     = gidx_next;
`ifdef TC_BITMEM_ARB_LOCK_EN
          if (sel_lock) begin
            state_d = StLocked;
            owner_d = gidx;
            ptr_d   = ptr_q;  // advanced past the owner on exit instead
          end
`endif
        end
      end
      StClear: begin
        cells_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NCELL - 1)) state_d = StIdle;
      end
`ifdef TC_BITMEM_ARB_LOCK_EN
      StLocked: begin
        if (clr) pend_d = 1'b1;
        if (sel_req) begin
          do_access = 1'b1;
        end else if (!sel_lock) begin
          // Release: a clear held back during the lock starts right away
          ptr_d   = gidx_next;
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = (pend_q || clr) ? StClear : StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (do_access) begin
      ack_d[gidx] = 1'b1;
      if (sel_we) begin
        cells_d[sel_addr] = sel_wdata;
        rdata_d           = sel_wdata;
      end else begin
        rdata_d = cells_q[sel_addr];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      cells_q <= '0;
      ack_q   <= '0;
      rdata_q <= 1'b0;
`ifdef TC_BITMEM_ARB_LOCK_EN
      owner_q <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cells_q <= cells_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifdef TC_BITMEM_ARB_LOCK_EN
      owner_q <= owner_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q == StClear);
  assign cells = cells_q;

endmodule
